// File: rtl/mips_multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl_if
// Memory handshake bundle between the multi-cycle controller and the
// instruction/data memories.
//   imem_req   : controller requests an instruction fetch
//   imem_ready : instruction memory has the instruction on the bus
//   dmem_req   : controller requests a data access
//   dmem_we    : data access is a write (valid with dmem_req)
//   mem_size   : 00 byte, 01 half, 10 word (valid with dmem_req)
//   dmem_ready : data memory completes the access this cycle
// master = controller side, slave = memory side.
// ---------------------------------------------------------------------------
interface mips_multicycle_ctrl_if;
  logic       imem_req;
  logic       imem_ready;
  logic       dmem_req;
  logic       dmem_ready;
  logic       dmem_we;
  logic [1:0] mem_size;

  modport master (
    output imem_req, dmem_req, dmem_we, mem_size,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we, mem_size,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
// Multi-cycle control FSM for the MIPS_32 datapath. Sequences one instruction
// at a time through FETCH/DECODE/EXEC/MEM/WB, handshakes with the memories,
// traps on illegal encodings or memory timeouts, counts retired instructions.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   opcode, funct       : IR fields, valid from DECODE until the next ir_load
//   alu_branch          : ALU branch-condition result, used in EXEC only
//   mem_if (master)     : imem/dmem request/ready handshake, dmem_we, mem_size
//   ir_load .. reg_write: datapath enables, decoded from state and opcode
//   err                 : sticky error code (01 opcode, 10 funct, 11 timeout)
//   state               : debug view of the FSM state
//   instr_count         : retired instruction count, wraps
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             opcode,
  input  logic [5:0]             funct,
  input  logic                   alu_branch,
  mips_multicycle_ctrl_if.master mem_if,
  output logic                   ir_load,
  output logic                   pc_write,
  output logic                   pc_src,
  output logic                   regs_load,
  output logic                   alu_out_load,
  output logic                   mem_to_reg,
  output logic                   reg_dst,
  output logic                   reg_write,
  output logic [1:0]             err,
  output logic [2:0]             state,
  output logic [CNT_W-1:0]       instr_count
);

  // The wait counter only needs to reach MEM_TIMEOUT-1: the low cycle seen
  // while it holds that value is the last one allowed.
  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  localparam logic [1:0] ERR_OPCODE  = 2'b01;
  localparam logic [1:0] ERR_FUNCT   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  state_e            state_q, state_d;
  logic [1:0]        err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              retire;

  logic is_rtype, is_imm, is_branch, is_store, is_load, funct_ok, opcode_ok;

  assign is_rtype  = (opcode == 6'b000000);
  assign is_imm    = opcode inside {6'b001000, 6'b001100, 6'b001101, 6'b001010};
  assign is_branch = opcode inside {6'b000100, 6'b000101, 6'b000001};
  assign is_store  = opcode inside {6'b101000, 6'b101001, 6'b101011};
  assign is_load   = opcode inside {6'b100000, 6'b100001, 6'b100011};
  assign funct_ok  = funct inside {6'b100000, 6'b100010, 6'b100100,
                                   6'b100111, 6'b100101, 6'b101010};
  assign opcode_ok = is_rtype | is_imm | is_branch | is_store | is_load;

  // State, error, retire counter and wait counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      err_q   <= 2'b00;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic. The wait counter is zero in every state except while
  // counting low-ready cycles, so it is already clear on entry to FETCH/MEM.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    wait_d  = '0;
    retire  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (mem_if.imem_ready) begin
          state_d = ST_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_TRAP;
          err_d   = ERR_TIMEOUT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DECODE: begin
        if (!opcode_ok) begin
          state_d = ST_TRAP;
          err_d   = ERR_OPCODE;
        end else if (is_rtype && !funct_ok) begin
          state_d = ST_TRAP;
          err_d   = ERR_FUNCT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_branch) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end else if (is_load || is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_if.dmem_ready) begin
          if (is_store) begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_TRAP;
          err_d   = ERR_TIMEOUT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
    cnt_d = retire ? (cnt_q + 1'b1) : cnt_q;
  end

  // Output decode. Everything is forced low while reset is high.
  always_comb begin
    mem_if.imem_req = 1'b0;
    mem_if.dmem_req = 1'b0;
    mem_if.dmem_we  = 1'b0;
    mem_if.mem_size = 2'b00;
    ir_load         = 1'b0;
    pc_write        = 1'b0;
    pc_src          = 1'b0;
    regs_load       = 1'b0;
    alu_out_load    = 1'b0;
    mem_to_reg      = 1'b0;
    reg_dst         = 1'b0;
    reg_write       = 1'b0;
    err             = 2'b00;
    state           = 3'd0;
    instr_count     = '0;
    if (reset) begin
      state = 3'd0;
    end else begin
      state       = state_q;
      err         = err_q;
      instr_count = cnt_q;
      case (state_q)
        ST_FETCH: begin
          mem_if.imem_req = 1'b1;
          ir_load         = mem_if.imem_ready;
          pc_write        = mem_if.imem_ready;
        end
        ST_DECODE: begin
          regs_load = 1'b1;
        end
        ST_EXEC: begin
          if (is_branch) begin
            pc_write = alu_branch;
            pc_src   = alu_branch;
          end else begin
            alu_out_load = 1'b1;
          end
        end
        ST_MEM: begin
          mem_if.dmem_req = 1'b1;
          mem_if.dmem_we  = is_store;
          case (opcode[1:0])
            2'b00:   mem_if.mem_size = 2'b00;
            2'b01:   mem_if.mem_size = 2'b01;
            2'b11:   mem_if.mem_size = 2'b10;
            default: mem_if.mem_size = 2'b00;
          endcase
        end
        ST_WB: begin
          reg_write  = 1'b1;
          reg_dst    = is_rtype;
          mem_to_reg = is_load;
        end
        default: begin
          reg_write = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Self-checking bench for mips_multicycle_ctrl. Directed scenarios plus a
// randomized instruction stream checked against a per-instruction model that
// expands each instruction into its expected cycle-by-cycle trace.
// Inputs are driven just after the falling edge and outputs sampled 1 time
// unit later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;
  localparam int TO = 16;
  localparam int CW = 4;   // narrow counter so the wrap is reached

  // Packed view of the enables: {imem_req, ir_load, pc_write, pc_src,
  // regs_load, alu_out_load, dmem_req, dmem_we, mem_size[1:0], mem_to_reg,
  // reg_dst, reg_write}
  localparam logic [12:0] IREQ = 13'h1000, IRLD = 13'h0800, PCW  = 13'h0400;
  localparam logic [12:0] PCS  = 13'h0200, RL   = 13'h0100, AL   = 13'h0080;
  localparam logic [12:0] DREQ = 13'h0040, DWE  = 13'h0020, SZW  = 13'h0010;
  localparam logic [12:0] SZH  = 13'h0008, M2R  = 13'h0004, RDST = 13'h0002;
  localparam logic [12:0] RW   = 13'h0001;
  localparam logic [12:0] FRDY = 13'h1C00;   // fetch completing

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode, funct;
  logic          alu_branch;
  logic          ir_load, pc_write, pc_src, regs_load, alu_out_load;
  logic          mem_to_reg, reg_dst, reg_write;
  logic [1:0]    err;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;

  int total = 0;
  int bad   = 0;

  mips_multicycle_ctrl_if mif();

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .alu_branch(alu_branch), .mem_if(mif.master),
    .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src),
    .regs_load(regs_load), .alu_out_load(alu_out_load),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .err(err), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] obs();
    obs = {mif.imem_req, ir_load, pc_write, pc_src, regs_load, alu_out_load,
           mif.dmem_req, mif.dmem_we, mif.mem_size, mem_to_reg, reg_dst, reg_write};
  endfunction

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic ir, input logic dr, input logic ab);
    opcode = op; funct = fn; mif.imem_ready = ir; mif.dmem_ready = dr; alu_branch = ab;
  endtask

  // Hold reset for two rising edges; returns at a falling edge with reset low.
  task automatic do_reset;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); reset = 1'b1;
    drive(6'b000000, 6'b100000, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      #1; total++;
      if (obs() !== 13'h0 || state !== 3'd0 || err !== 2'd0 || instr_count !== 4'd0) begin
        bad++;
        $display("FAIL reset_outs cyc=%0d outs=%h state=%0d err=%0d cnt=%0d expected all zero",
                 i, obs(), state, err, instr_count);
      end
    end
    @(negedge clk); reset = 1'b0; #1; total++;
    if (state !== 3'd0 || obs() !== FRDY) begin
      bad++;
      $display("FAIL reset_exit state=%0d outs=%h expected state=0 outs=%h", state, obs(), FRDY);
    end
  endtask

  task automatic test_rtype_add;
    logic [2:0]  es[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    logic [12:0] eo[5] = '{FRDY, RL, AL, RW | RDST, FRDY};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      drive(6'b000000, 6'b100000, 1'b1, 1'b1, 1'($urandom));
      #1; total++;
      if (state !== es[i] || obs() !== eo[i]) begin
        bad++;
        $display("FAIL add_seq cyc=%0d state=%0d outs=%h expected state=%0d outs=%h",
                 i, state, obs(), es[i], eo[i]);
      end
    end
    total++;
    if (instr_count !== 4'd1) begin
      bad++; $display("FAIL add_count got=%0d expected=1", instr_count);
    end
  endtask

  task automatic test_lw_wait;
    logic [2:0]  es[9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    logic        dr[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [12:0] eo[9] = '{FRDY, RL, AL, DREQ | SZW, DREQ | SZW, DREQ | SZW, DREQ | SZW,
                           RW | M2R, FRDY};
    logic [CW-1:0] ec[9] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      drive(6'b100011, 6'($urandom), 1'b1, dr[i], 1'($urandom));
      #1; total++;
      if (state !== es[i] || obs() !== eo[i] || instr_count !== ec[i]) begin
        bad++;
        $display("FAIL lw_wait cyc=%0d state=%0d outs=%h cnt=%0d expected state=%0d outs=%h cnt=%0d",
                 i, state, obs(), instr_count, es[i], eo[i], ec[i]);
      end
    end
  endtask

  task automatic test_branch;
    logic [2:0]  es[7] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
    logic [12:0] eo[7] = '{FRDY, RL, PCW | PCS, FRDY, RL, 13'h0, FRDY};
    logic [CW-1:0] ec[7] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
    logic ab;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      ab = (i == 2) ? 1'b1 : (i == 5) ? 1'b0 : 1'($urandom);
      drive(6'b000100, 6'($urandom), 1'b1, 1'($urandom), ab);
      #1; total++;
      if (state !== es[i] || obs() !== eo[i] || instr_count !== ec[i]) begin
        bad++;
        $display("FAIL beq cyc=%0d state=%0d outs=%h cnt=%0d expected state=%0d outs=%h cnt=%0d",
                 i, state, obs(), instr_count, es[i], eo[i], ec[i]);
      end
    end
  endtask

  task automatic test_illegal;
    logic [2:0]  es2[9] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd7, 3'd7, 3'd7, 3'd7};
    logic [12:0] eo2[9] = '{FRDY, RL, 13'h0, FRDY, RL, 13'h0, 13'h0, 13'h0, 13'h0};
    logic [1:0]  ee2[9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2};
    logic [CW-1:0] ec2[9] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    logic [2:0]  es;
    logic [12:0] eo;
    logic [1:0]  ee;
    // Illegal opcode: trap after DECODE, then only err is visible.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      drive(6'b111111, 6'($urandom), (i < 2) ? 1'b1 : 1'($urandom), 1'($urandom), 1'($urandom));
      es = (i == 0) ? 3'd0 : (i == 1) ? 3'd1 : 3'd7;
      eo = (i == 0) ? FRDY : (i == 1) ? RL : 13'h0;
      ee = (i < 2) ? 2'd0 : 2'd1;
      #1; total++;
      if (state !== es || obs() !== eo || err !== ee || instr_count !== 4'd0) begin
        bad++;
        $display("FAIL ill_opcode cyc=%0d state=%0d outs=%h err=%0d expected state=%0d outs=%h err=%0d",
                 i, state, obs(), err, es, eo, ee);
      end
    end
    @(negedge clk); reset = 1'b1; #1; total++;
    if (err !== 2'd0) begin
      bad++; $display("FAIL ill_reset_clear err=%0d expected=0", err);
    end
    // Not-taken beq retires, then an R-type with funct 000000 traps; count held.
    @(negedge clk); @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      drive((i < 3) ? 6'b000100 : 6'b000000, 6'b000000, 1'b1, 1'($urandom),
            (i == 2) ? 1'b0 : 1'($urandom));
      #1; total++;
      if (state !== es2[i] || obs() !== eo2[i] || err !== ee2[i] || instr_count !== ec2[i]) begin
        bad++;
        $display("FAIL ill_funct cyc=%0d state=%0d outs=%h err=%0d cnt=%0d expected state=%0d outs=%h err=%0d cnt=%0d",
                 i, state, obs(), err, instr_count, es2[i], eo2[i], ee2[i], ec2[i]);
      end
    end
  endtask

  task automatic test_fetch_timeout;
    logic [2:0]  es;
    logic [12:0] eo;
    logic [1:0]  ee;
    // 16 low cycles in FETCH trap on the following cycle.
    do_reset();
    for (int i = 0; i <= TO; i++) begin
      if (i > 0) @(negedge clk);
      drive(6'b000000, 6'b100000, 1'b0, 1'($urandom), 1'($urandom));
      es = (i < TO) ? 3'd0 : 3'd7;
      eo = (i < TO) ? IREQ : 13'h0;
      ee = (i < TO) ? 2'd0 : 2'd3;
      #1; total++;
      if (state !== es || obs() !== eo || err !== ee) begin
        bad++;
        $display("FAIL fetch_to cyc=%0d state=%0d outs=%h err=%0d expected state=%0d outs=%h err=%0d",
                 i, state, obs(), err, es, eo, ee);
      end
    end
    // Ready arriving on the 16th FETCH cycle still wins.
    do_reset();
    for (int i = 0; i <= TO; i++) begin
      if (i > 0) @(negedge clk);
      drive(6'b000000, 6'b100000, (i == TO - 1) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      es = (i < TO) ? 3'd0 : 3'd1;
      eo = (i < TO - 1) ? IREQ : (i == TO - 1) ? FRDY : RL;
      #1; total++;
      if (state !== es || obs() !== eo || err !== 2'd0) begin
        bad++;
        $display("FAIL fetch_late cyc=%0d state=%0d outs=%h err=%0d expected state=%0d outs=%h err=0",
                 i, state, obs(), err, es, eo);
      end
    end
  endtask

  task automatic test_mem_timeout;
    logic [2:0]  es;
    logic [12:0] eo;
    logic [1:0]  ee;
    // sw with data memory never ready: MEM lasts 16 cycles then TRAP.
    do_reset();
    for (int i = 0; i < TO + 4; i++) begin
      if (i > 0) @(negedge clk);
      drive(6'b101011, 6'($urandom), 1'b1, 1'b0, 1'($urandom));
      es = (i < 3) ? 3'(i) : (i < TO + 3) ? 3'd3 : 3'd7;
      eo = (i == 0) ? FRDY : (i == 1) ? RL : (i == 2) ? AL :
           (i < TO + 3) ? (DREQ | DWE | SZW) : 13'h0;
      ee = (i < TO + 3) ? 2'd0 : 2'd3;
      #1; total++;
      if (state !== es || obs() !== eo || err !== ee) begin
        bad++;
        $display("FAIL mem_to cyc=%0d state=%0d outs=%h err=%0d expected state=%0d outs=%h err=%0d",
                 i, state, obs(), err, es, eo, ee);
      end
    end
    // lh whose data arrives on the 16th MEM cycle completes normally.
    do_reset();
    for (int i = 0; i < TO + 5; i++) begin
      if (i > 0) @(negedge clk);
      drive(6'b100001, 6'($urandom), 1'b1, (i == TO + 2) ? 1'b1 : 1'b0, 1'($urandom));
      es = (i < 3) ? 3'(i) : (i < TO + 3) ? 3'd3 : (i == TO + 3) ? 3'd4 : 3'd0;
      eo = (i == 0) ? FRDY : (i == 1) ? RL : (i == 2) ? AL :
           (i < TO + 3) ? (DREQ | SZH) : (i == TO + 3) ? (RW | M2R) : FRDY;
      #1; total++;
      if (state !== es || obs() !== eo || err !== 2'd0) begin
        bad++;
        $display("FAIL mem_late cyc=%0d state=%0d outs=%h err=%0d expected state=%0d outs=%h err=0",
                 i, state, obs(), err, es, eo);
      end
    end
  endtask

  task automatic test_store_reset;
    logic [5:0]  op[15] = '{6'b101000, 6'b101000, 6'b101000, 6'b101000, 6'b101001, 6'b101001,
                            6'b101001, 6'b101001, 6'b101011, 6'b101011, 6'b101011, 6'b101011,
                            6'b101011, 6'b101011, 6'b101011};
    logic        ir[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b0};
    logic        dr[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b0};
    logic        rs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  es[15] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2,
                            3'd3, 3'd0, 3'd0, 3'd0};
    logic [12:0] eo[15] = '{FRDY, RL, AL, DREQ | DWE, FRDY, RL, AL, DREQ | DWE | SZH, FRDY,
                            RL, AL, DREQ | DWE | SZW, 13'h0, 13'h0, IREQ};
    logic [CW-1:0] ec[15] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2,
                              4'd2, 4'd2, 4'd0, 4'd0, 4'd0};
    do_reset();
    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      reset = rs[i];
      drive(op[i], 6'($urandom), ir[i], dr[i], 1'($urandom));
      #1; total++;
      if (state !== es[i] || obs() !== eo[i] || instr_count !== ec[i] || err !== 2'd0) begin
        bad++;
        $display("FAIL store_rst cyc=%0d state=%0d outs=%h cnt=%0d err=%0d expected state=%0d outs=%h cnt=%0d err=0",
                 i, state, obs(), instr_count, err, es[i], eo[i], ec[i]);
      end
    end
  endtask

  // Expected trace of one instruction, one entry per cycle.
  logic [2:0]  q_st[$];
  logic [12:0] q_o[$];
  logic        q_ir[$], q_dr[$], q_ab[$];

  task automatic push(input logic [2:0] st, input logic [12:0] o,
                      input logic ir, input logic dr, input logic ab);
    q_st.push_back(st); q_o.push_back(o);
    q_ir.push_back(ir); q_dr.push_back(dr); q_ab.push_back(ab);
  endtask

  task automatic test_random;
    logic [5:0] ops[14] = '{6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b001010,
                            6'b000100, 6'b000101, 6'b000001, 6'b101000, 6'b101001,
                            6'b101011, 6'b100000, 6'b100001, 6'b100011};
    logic [5:0] fns[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100111, 6'b100101, 6'b101010};
    logic [5:0]    op, fn;
    logic [12:0]   mo;
    logic [CW-1:0] exp_cnt;
    logic          br, is_br, is_st, is_ld;
    int            id, dd;
    bit            first;
    do_reset();
    exp_cnt = '0;
    first   = 1'b1;
    for (int n = 0; n < 60; n++) begin
      op    = ops[$urandom_range(13, 0)];
      fn    = (op == 6'b000000) ? fns[$urandom_range(5, 0)] : 6'($urandom);
      id    = $urandom_range(5, 0);
      dd    = $urandom_range(5, 0);
      br    = 1'($urandom);
      is_br = op inside {6'b000100, 6'b000101, 6'b000001};
      is_st = op inside {6'b101000, 6'b101001, 6'b101011};
      is_ld = op inside {6'b100000, 6'b100001, 6'b100011};
      case (op)
        6'b101000, 6'b100000: mo = DREQ;
        6'b101001, 6'b100001: mo = DREQ | SZH;
        default:              mo = DREQ | SZW;
      endcase
      if (is_st) mo = mo | DWE;
      q_st.delete(); q_o.delete(); q_ir.delete(); q_dr.delete(); q_ab.delete();
      for (int j = 0; j < id; j++) push(3'd0, IREQ, 1'b0, 1'($urandom), 1'($urandom));
      push(3'd0, FRDY, 1'b1, 1'($urandom), 1'($urandom));
      push(3'd1, RL, 1'($urandom), 1'($urandom), 1'($urandom));
      if (is_br) push(3'd2, br ? (PCW | PCS) : 13'h0, 1'($urandom), 1'($urandom), br);
      else       push(3'd2, AL, 1'($urandom), 1'($urandom), 1'($urandom));
      if (is_st || is_ld) begin
        for (int j = 0; j < dd; j++) push(3'd3, mo, 1'($urandom), 1'b0, 1'($urandom));
        push(3'd3, mo, 1'($urandom), 1'b1, 1'($urandom));
      end
      if (!is_br && !is_st)
        push(3'd4, RW | ((op == 6'b000000) ? RDST : 13'h0) | (is_ld ? M2R : 13'h0),
             1'($urandom), 1'($urandom), 1'($urandom));
      for (int i = 0; i < q_st.size(); i++) begin
        if (!first) @(negedge clk);
        first = 1'b0;
        drive(op, fn, q_ir[i], q_dr[i], q_ab[i]);
        #1; total++;
        if (state !== q_st[i] || obs() !== q_o[i] || err !== 2'd0 || instr_count !== exp_cnt) begin
          bad++;
          $display("FAIL rand n=%0d op=%b cyc=%0d state=%0d outs=%h err=%0d cnt=%0d expected state=%0d outs=%h err=0 cnt=%0d",
                   n, op, i, state, obs(), err, instr_count, q_st[i], q_o[i], exp_cnt);
        end
      end
      exp_cnt = exp_cnt + 1'b1;
    end
    @(negedge clk);
    drive(6'b000000, 6'b100000, 1'b0, 1'b0, 1'b0);
    #1; total++;
    if (instr_count !== exp_cnt || state !== 3'd0) begin
      bad++;
      $display("FAIL rand_final cnt=%0d state=%0d expected cnt=%0d state=0", instr_count, state, exp_cnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_rtype_add();
    test_lw_wait();
    test_branch();
    test_illegal();
    test_fetch_timeout();
    test_mem_timeout();
    test_store_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
